srv6_endpoint: RTL and testbench

Parametrised SRv6 endpoint (End behaviour) for the 512-bit packet datapath, second generation of the SRv6 rewrite block. It stores each packet in an internal buffer and decides its fate. When the packet carries a Segment Routing Header, the block decrements Segments Left and writes the selected segment into the IPv6 destination address. It then forwards the packet with valid/ready flow control on both sides. It handles segments lying in any beat, oversized packets and back-pressure, which the first generation did not.

---
 rtl/srv6_endpoint.sv | 210 +++++++++++++++++++++
 tb/tb_srv6_endpoint.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srv6_endpoint.sv
// SRv6 End endpoint: stores each packet, rewrites DA/SL on egress beat 0, forwards with valid/ready.
// Optional macro SRV6_HOPLIMIT_EN: SRv6 packets get Hop Limit decremented; those arriving with HL<=1 are dropped.
// Handshake: a beat moves when valid && ready; out_data/out_last hold while out_valid && !out_ready.
module srv6_endpoint #(
  parameter int DATA_W   = 512,
  parameter int BUF_AW   = 6,
  parameter int MAX_SEGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              drop,
  output logic              seg_err,
  output logic [31:0]       pkt_count,
  output logic [31:0]       drop_count,
  output logic [1:0]        dbg_state
);

  localparam int              DEPTH  = 1 << BUF_AW;
  localparam logic [BUF_AW:0] FULL   = (BUF_AW+1)'(DEPTH);
  localparam logic [8:0]      MAX_SL = 9'(MAX_SEGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [BUF_AW:0]   r_wptr, r_rptr;
  logic              r_is_srv6, r_seg_need, r_seg_got, r_rewrite;
  logic [6:0]        r_seg_beat;
  logic [1:0]        r_seg_lane;
  logic [127:0]      r_seg;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid, r_out_last;
  logic              r_drop, r_seg_err;
  logic [31:0]       r_pkt_cnt, r_drop_cnt;

  logic [7:0]        w_nh, w_rt, w_sl;
  logic [8:0]        w_idx;
  logic              w_is_srv6, w_sl_ok, w_hl_drop, w_acc, w_full;
  logic              w_cap_now, w_srv6_cur, w_got_final, w_fwd_end, w_drop_end;
  logic              w_load, w_out_hs, w_send_done, w_wr_en;
  logic [1:0]        w_lane_sel;
  logic [127:0]      w_lane_data;
  logic [DATA_W-1:0] w_rd, w_patched;

  assign w_nh      = in_data[463:456];
  assign w_rt      = in_data[175:168];
  assign w_sl      = in_data[167:160];
  assign w_is_srv6 = (w_nh == 8'd43) && (w_rt == 8'd4) && (w_sl != 8'd0);
  assign w_sl_ok   = {1'b0, w_sl} <= MAX_SL;
  // seg[i] is 128-bit word i+3 of the packet, i.e. word SL+2
  assign w_idx     = {1'b0, w_sl} + 9'd2;

`ifdef SRV6_HOPLIMIT_EN
  logic [7:0] w_hl;
  assign w_hl      = in_data[455:448];
  assign w_hl_drop = w_is_srv6 && (w_hl <= 8'd1);
`else
  assign w_hl_drop = 1'b0;
`endif

  assign in_ready  = !reset && (r_state != ST_SEND);
  assign w_acc     = in_valid && in_ready;
  assign w_full    = (r_wptr == FULL);

  assign w_cap_now = w_acc && (
    ((r_state == ST_IDLE) && w_is_srv6 && w_sl_ok && (w_idx[8:2] == 7'd0)) ||
    ((r_state == ST_RECV) && !w_full && r_seg_need && !r_seg_got &&
     (r_wptr == (BUF_AW+1)'(r_seg_beat))));

  assign w_srv6_cur  = (r_state == ST_IDLE) ? w_is_srv6 : r_is_srv6;
  assign w_got_final = w_cap_now || ((r_state != ST_IDLE) && r_seg_got);

  assign w_fwd_end  = w_acc && in_last &&
                      (((r_state == ST_IDLE) && !w_hl_drop) || ((r_state == ST_RECV) && !w_full));
  assign w_drop_end = w_acc && in_last &&
                      (((r_state == ST_IDLE) && w_hl_drop) || ((r_state == ST_RECV) && w_full) ||
                       (r_state == ST_DROP));

  assign w_wr_en     = w_acc && ((r_state == ST_IDLE) || ((r_state == ST_RECV) && !w_full));
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_load      = (r_state == ST_SEND) && (r_rptr != r_wptr) && (!r_out_valid || out_ready);
  assign w_send_done = (r_state == ST_SEND) && w_out_hs && r_out_last;
  assign w_lane_sel  = (r_state == ST_IDLE) ? w_idx[1:0] : r_seg_lane;
  assign w_rd        = r_mem[r_rptr[BUF_AW-1:0]];

  always_comb begin
    w_lane_data = in_data[127:0];
    case (w_lane_sel)
      2'd0:    w_lane_data = in_data[511:384];
      2'd1:    w_lane_data = in_data[383:256];
      2'd2:    w_lane_data = in_data[255:128];
      default: w_lane_data = in_data[127:0];
    endcase
  end

  always_comb begin
    w_patched = w_rd;
    if ((r_rptr == '0) && r_rewrite) begin
      w_patched[319:192] = r_seg;
      w_patched[167:160] = w_rd[167:160] - 8'd1;
`ifdef SRV6_HOPLIMIT_EN
      w_patched[455:448] = w_rd[455:448] - 8'd1;
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_acc) begin
        if (w_hl_drop) w_next = in_last ? ST_IDLE : ST_DROP;
        else           w_next = in_last ? ST_SEND : ST_RECV;
      end
      ST_RECV: if (w_acc) begin
        if (w_full)       w_next = in_last ? ST_IDLE : ST_DROP;
        else if (in_last) w_next = ST_SEND;
      end
      ST_DROP: if (w_acc && in_last) w_next = ST_IDLE;
      ST_SEND: if (w_send_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[(r_state == ST_IDLE) ? '0 : r_wptr[BUF_AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_is_srv6   <= 1'b0;
      r_seg_need  <= 1'b0;
      r_seg_got   <= 1'b0;
      r_rewrite   <= 1'b0;
      r_seg_beat  <= '0;
      r_seg_lane  <= '0;
      r_seg       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_drop      <= 1'b0;
      r_seg_err   <= 1'b0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_drop    <= w_drop_end;
      r_seg_err <= w_fwd_end && w_srv6_cur && !w_got_final;
      if (w_drop_end)  r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_send_done) r_pkt_cnt  <= r_pkt_cnt + 32'd1;

      if ((r_state == ST_IDLE) && w_acc) begin
        r_wptr     <= (BUF_AW+1)'(1);
        r_is_srv6  <= w_is_srv6;
        r_seg_need <= w_is_srv6 && w_sl_ok;
        r_seg_beat <= w_idx[8:2];
        r_seg_lane <= w_idx[1:0];
        r_seg_got  <= 1'b0;
      end else if ((r_state == ST_RECV) && w_acc && !w_full) begin
        r_wptr <= r_wptr + (BUF_AW+1)'(1);
      end

      if (w_cap_now) begin
        r_seg     <= w_lane_data;
        r_seg_got <= 1'b1;
      end

      if (w_fwd_end) begin
        r_rewrite <= w_srv6_cur && w_got_final;
        r_rptr    <= '0;
      end

      // registered read doubles as the egress holding register
      if (w_load) begin
        r_out_data  <= w_patched;
        r_out_valid <= 1'b1;
        r_out_last  <= ((r_rptr + (BUF_AW+1)'(1)) == r_wptr);
        r_rptr      <= r_rptr + (BUF_AW+1)'(1);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign drop       = r_drop;
  assign seg_err    = r_seg_err;
  assign pkt_count  = r_pkt_cnt;
  assign drop_count = r_drop_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_srv6_endpoint.sv
// Bench for srv6_endpoint: directed vector table, hand sequences and random packets
// checked against a flat 128-bit-word packet model and an egress scoreboard.
module tb_srv6_endpoint;
  localparam int W        = 512;
  localparam int DEPTH    = 64;
  localparam int MAX_SEGS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid, in_last, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last, out_ready;
  logic          drop, seg_err;
  logic [31:0]   pkt_count, drop_count;
  logic [1:0]    dbg_state;

  srv6_endpoint dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .drop(drop), .seg_err(seg_err), .pkt_count(pkt_count), .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_pkt_cnt = 0;
  int exp_drop_cnt = 0;
  int seen_seg = 0;
  int seen_drop = 0;
  int last_hs_cyc = 0;
  int rdy_mode = 0;

  logic [W-1:0] exp_q[$];
  bit           exp_last_q[$];
  logic [W-1:0] pkt [0:DEPTH+7];
  int           pkt_n;

  typedef struct {
    logic [7:0] nh, rt, sl, hl;
    int         nb;
    bit         e_seg, e_drop;
    int         rdy;
    bit         lat;
  } vec_t;

  task automatic check(input string name, input logic [W+7:0] act, input logic [W+7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // downstream ready: 0 = always, 1 = toggling, 2 = random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // egress monitor and scoreboard
  initial begin
    bit           held;
    logic [W+7:0] held_vec;
    logic [W-1:0] e;
    bit           el;
    held = 0;
    held_vec = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (held) check("hold_stable", {6'd0, out_valid, out_last, out_data}, held_vec);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h, expected no beat", out_data);
          end else begin
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check("egress_data", {8'd0, out_data}, {8'd0, e});
            check("egress_last", (W+8)'(out_last), (W+8)'(el));
          end
        end
        held     = out_valid && !out_ready;
        held_vec = {6'd0, out_valid, out_last, out_data};
        if (drop)    seen_drop++;
        if (seg_err) seen_seg++;
      end else begin
        held = 0;
      end
    end
  end

  task automatic build_pkt(input logic [7:0] nh, rt, sl, hl, input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < W / 32; j++) pkt[k][j*32 +: 32] = $urandom;
    pkt[0][463:456] = nh;
    pkt[0][455:448] = hl;
    pkt[0][175:168] = rt;
    pkt[0][167:160] = sl;
    pkt_n = n;
  endtask

  // Reference: the packet is a flat list of 128-bit words, seg[i] is word i+3.
  function automatic void model(output bit m_seg, output bit m_drop);
    logic [7:0]   nh, rt, sl, hl;
    logic [W-1:0] b0;
    bit           srv6;
    int           word;
    b0 = pkt[0];
    nh = b0[463:456];
    hl = b0[455:448];
    rt = b0[175:168];
    sl = b0[167:160];
    srv6 = (nh == 8'd43) && (rt == 8'd4) && (sl != 8'd0);
    m_seg = 0;
    m_drop = (pkt_n > DEPTH);
`ifdef SRV6_HOPLIMIT_EN
    if (srv6 && hl <= 8'd1) m_drop = 1;
`endif
    if (m_drop) begin
      exp_drop_cnt++;
      return;
    end
    if (srv6) begin
      word = int'(sl) - 1 + 3;
      if (int'(sl) <= MAX_SEGS && word < 4 * pkt_n) begin
        b0[319:192] = pkt[word / 4][511 - 128 * (word % 4) -: 128];
        b0[167:160] = sl - 8'd1;
`ifdef SRV6_HOPLIMIT_EN
        b0[455:448] = hl - 8'd1;
`endif
      end else begin
        m_seg = 1;
      end
    end
    exp_q.push_back(b0);
    exp_last_q.push_back(pkt_n == 1);
    for (int k = 1; k < pkt_n; k++) begin
      exp_q.push_back(pkt[k]);
      exp_last_q.push_back(k == pkt_n - 1);
    end
    exp_pkt_cnt++;
  endfunction

  // called and returns just after a rising edge
  task automatic drive_beat(input logic [W-1:0] d, input bit last, input bit gap);
    int t;
    bit ok;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    ok = 0;
    while (!ok && t < 2000) begin
      @(negedge clk);
      ok = in_ready;
      if (ok && last) last_hs_cyc = cyc;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL ingress_timeout: in_ready 0 for %0d cycles, expected 1", t);
    end
  endtask

  task automatic run_pkt(input bit e_seg, input bit e_drop, input bit gaps, input bit chk_lat);
    int s0, d0, t;
    s0 = seen_seg;
    d0 = seen_drop;
    for (int k = 0; k < pkt_n; k++)
      drive_beat(pkt[k], k == pkt_n - 1, gaps && ($urandom_range(0, 2) == 0));
    if (chk_lat) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 50);
      check("first_valid_latency", (W+8)'(cyc - last_hs_cyc), (W+8)'(2));
      check("in_ready_in_send", (W+8)'(in_ready), (W+8)'(0));
      while (!(out_valid && out_ready && out_last) && t < 200) begin @(negedge clk); t++; end
      @(negedge clk);
      check("in_ready_after_send", (W+8)'(in_ready), (W+8)'(1));
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!(exp_q.size() == 0 && in_ready) && t < 3000);
    if (t >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL egress_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_last_q.delete();
    end
    repeat (2) @(negedge clk);
    check("seg_err_pulses", (W+8)'(seen_seg - s0), (W+8)'(e_seg));
    check("drop_pulses", (W+8)'(seen_drop - d0), (W+8)'(e_drop));
    check("pkt_count", (W+8)'(pkt_count), (W+8)'(32'(exp_pkt_cnt)));
    check("drop_count", (W+8)'(drop_count), (W+8)'(32'(exp_drop_cnt)));
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit hit, expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [12];
    bit         m_seg, m_drop;
    logic [7:0] nh, rt, sl, hl;

    tbl[0]  = '{8'd6,  8'd0, 8'd0,  8'd64, 3,  1'b0, 1'b0, 0, 1'b1};
    tbl[1]  = '{8'd43, 8'd4, 8'd1,  8'd64, 1,  1'b0, 1'b0, 0, 1'b0};
    tbl[2]  = '{8'd43, 8'd4, 8'd6,  8'd64, 4,  1'b0, 1'b0, 1, 1'b0};
    tbl[3]  = '{8'd43, 8'd4, 8'd9,  8'd64, 2,  1'b1, 1'b0, 0, 1'b0};
    tbl[4]  = '{8'd43, 8'd4, 8'd17, 8'd64, 2,  1'b1, 1'b0, 2, 1'b0};
    tbl[5]  = '{8'd43, 8'd4, 8'd16, 8'd64, 5,  1'b0, 1'b0, 2, 1'b0};
    tbl[6]  = '{8'd43, 8'd4, 8'd16, 8'd64, 4,  1'b1, 1'b0, 1, 1'b0};
    tbl[7]  = '{8'd43, 8'd5, 8'd3,  8'd64, 2,  1'b0, 1'b0, 0, 1'b0};
    tbl[8]  = '{8'd43, 8'd4, 8'd0,  8'd64, 2,  1'b0, 1'b0, 0, 1'b0};
`ifdef SRV6_HOPLIMIT_EN
    tbl[9]  = '{8'd43, 8'd4, 8'd1,  8'd1,  2,  1'b0, 1'b1, 0, 1'b0};
`else
    tbl[9]  = '{8'd43, 8'd4, 8'd1,  8'd1,  2,  1'b0, 1'b0, 0, 1'b0};
`endif
    tbl[10] = '{8'd6,  8'd0, 8'd0,  8'd64, 67, 1'b0, 1'b1, 0, 1'b0};
    tbl[11] = '{8'd43, 8'd4, 8'd4,  8'd64, 2,  1'b0, 1'b0, 0, 1'b0};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", (W+8)'(in_ready), (W+8)'(0));
    check("rst_out_valid", (W+8)'(out_valid), (W+8)'(0));
    check("rst_out_last", (W+8)'(out_last), (W+8)'(0));
    check("rst_out_data", {8'd0, out_data}, '0);
    check("rst_drop", (W+8)'(drop), (W+8)'(0));
    check("rst_seg_err", (W+8)'(seg_err), (W+8)'(0));
    check("rst_pkt_count", (W+8)'(pkt_count), (W+8)'(0));
    check("rst_drop_count", (W+8)'(drop_count), (W+8)'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", (W+8)'(in_ready), (W+8)'(1));
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      build_pkt(tbl[k].nh, tbl[k].rt, tbl[k].sl, tbl[k].hl, tbl[k].nb);
      model(m_seg, m_drop);
      rdy_mode = tbl[k].rdy;
      run_pkt(tbl[k].e_seg, tbl[k].e_drop, (k % 3) == 2, tbl[k].lat);
    end

    // reset in the middle of a packet abandons it
    rdy_mode = 0;
    build_pkt(8'd43, 8'd4, 8'd6, 8'd64, 4);
    drive_beat(pkt[0], 1'b0, 1'b0);
    drive_beat(pkt[1], 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_pkt_cnt  = 0;
    exp_drop_cnt = 0;
    @(negedge clk);
    check("midpkt_rst_pkt_count", (W+8)'(pkt_count), (W+8)'(0));
    check("midpkt_rst_in_ready", (W+8)'(in_ready), (W+8)'(1));
    @(posedge clk); #1;
    build_pkt(8'd43, 8'd4, 8'd2, 8'd64, 2);
    model(m_seg, m_drop);
    run_pkt(1'b0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      nh = ($urandom_range(0, 3) == 0) ? 8'd6 : 8'd43;
      rt = ($urandom_range(0, 4) == 0) ? 8'd5 : 8'd4;
      sl = 8'($urandom_range(0, 20));
      hl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'd64;
      build_pkt(nh, rt, sl, hl, $urandom_range(1, 6));
      model(m_seg, m_drop);
      rdy_mode = $urandom_range(0, 2);
      run_pkt(m_seg, m_drop, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
